// File: rtl/fp_sched_pkg.sv
// Shared types and defaults for the FP issue scheduler: op classes,
// reservation entry layout and the per-class latency lookup.
package fp_sched_pkg;

  localparam int FP_TAG_W   = 5;
  localparam int FP_ADD_LAT = 3;
  localparam int FP_MUL_LAT = 4;
  localparam int FP_DIV_LAT = 12;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_MUL  = 2'd2,
    OP_DIV  = 2'd3
  } op_class_e;

  typedef struct packed {
    logic                valid;
    logic [FP_TAG_W-1:0] dest;
  } res_entry_t;

  // NONE never issues, so its latency value is never used to index a slot.
  function automatic int op_latency(input op_class_e op, input int add_lat,
                                    input int mul_lat, input int div_lat);
    case (op)
      OP_ADD:  return add_lat;
      OP_MUL:  return mul_lat;
      OP_DIV:  return div_lat;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/fp_wb_reservation_shifter.sv
// Writeback-port reservation shift register: one entry per future cycle,
// slot 0 is the result being written back this cycle.
module fp_wb_reservation_shifter
  import fp_sched_pkg::*;
#(
  parameter  int MAX_LAT = 16,
  localparam int LAT_W   = $clog2(MAX_LAT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ins_en,
  input  logic [LAT_W-1:0]    ins_idx,
  input  logic [FP_TAG_W-1:0] ins_dest,
  input  logic [LAT_W-1:0]    query_idx,
  output logic                query_valid,
  output res_entry_t          slot0
);

  res_entry_t res [MAX_LAT];

  // Insert lands at L-1 in the same edge as the shift, so it reaches slot 0 after L edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_LAT; i++) res[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_LAT - 1; i++) res[i] <= res[i+1];
      res[MAX_LAT-1] <= '0;
      if (ins_en) res[ins_idx] <= res_entry_t'{valid: 1'b1, dest: ins_dest};
    end
  end

  assign query_valid = res[query_idx].valid;
  assign slot0       = res[0];

endmodule

// File: rtl/fp_issue_scoreboard.sv
// FP issue scoreboard: RAW/WAW/writeback-port/divider hazard detection at ID.
// Optional macro FP_WB_BYPASS_EN lets a register being written back this cycle satisfy RAW/WAW.
module fp_issue_scoreboard
  import fp_sched_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADD_LAT  = FP_ADD_LAT,
  parameter int MUL_LAT  = FP_MUL_LAT,
  parameter int DIV_LAT  = FP_DIV_LAT,
  parameter int MAX_LAT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [1:0]          id_op_class,
  input  logic [FP_TAG_W-1:0] id_dest,
  input  logic [FP_TAG_W-1:0] id_src1,
  input  logic [FP_TAG_W-1:0] id_src2,
  input  logic                id_src1_en,
  input  logic                id_src2_en,
  input  logic                flush,
  output logic                stall_out,
  output logic                issue_out,
  output logic                wb_valid,
  output logic [FP_TAG_W-1:0] wb_dest,
  output logic                div_busy
);

  localparam int LAT_W = $clog2(MAX_LAT);
  localparam int DIV_W = $clog2(DIV_LAT + 1);

  op_class_e           op;
  logic [LAT_W-1:0]    lat;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_eff;
  logic [DIV_W-1:0]    div_cnt;
  logic                slot_taken;
  res_entry_t          slot0;
  logic                fp_req;
  logic                hazard;

  always_comb begin
    op  = op_class_e'(id_op_class);
    lat = LAT_W'(op_latency(op, ADD_LAT, MUL_LAT, DIV_LAT));
  end

`ifdef FP_WB_BYPASS_EN
  // The register file writes through, so the register retiring now is already readable.
  assign pending_eff = slot0.valid ? (pending & ~(NUM_REGS'(1) << slot0.dest)) : pending;
`else
  assign pending_eff = pending;
`endif

  always_comb begin
    fp_req    = id_valid && (op != OP_NONE) && !flush;
    hazard    = (id_src1_en && pending_eff[id_src1])
             || (id_src2_en && pending_eff[id_src2])
             || pending_eff[id_dest]
             || slot_taken
             || ((op == OP_DIV) && (div_cnt != '0));
    stall_out = fp_req && hazard;
    issue_out = fp_req && !hazard;
  end

  fp_wb_reservation_shifter #(
    .MAX_LAT(MAX_LAT)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .ins_en     (issue_out),
    .ins_idx    (lat - LAT_W'(1)),
    .ins_dest   (id_dest),
    .query_idx  (lat),
    .query_valid(slot_taken),
    .slot0      (slot0)
  );

  // The set is written last so it wins over a same-register writeback clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (slot0.valid) pending[slot0.dest] <= 1'b0;
      if (issue_out)   pending[id_dest]    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (issue_out && (op == OP_DIV)) begin
      div_cnt <= DIV_W'(DIV_LAT - 1);
    end else if (div_cnt != '0) begin
      div_cnt <= div_cnt - DIV_W'(1);
    end
  end

  assign wb_valid = slot0.valid;
  assign wb_dest  = slot0.dest;
  assign div_busy = (div_cnt != '0);

endmodule
